// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/gnt/rvalid bus handshake, pipeline freeze and MEMWB bubble.
// Define MEM_ACCESS_CTRL_TIMEOUT_EN to abort accesses that exceed TIMEOUT_CYC cycles in REQ+RESP.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        memwb_bubble_o,
    output logic [31:0] mem_rdata_o,
    output logic        fault_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        access_c;

    if (CNT_W < 32 && TIMEOUT_CYC >= (32'd1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to hold TIMEOUT_CYC");
    end

    assign access_c = valid_i & (mem_read_i | mem_write_i);

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             done_c;
    logic             abort_c;

    // Completion beats expiry when both land in the same cycle.
    assign done_c  = ((state_q == REQ) & bus_gnt_i & (bus_we_q | bus_rvalid_i)) |
                     ((state_q == RESP) & bus_rvalid_i);
    assign abort_c = ((state_q == REQ) | (state_q == RESP)) &
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) & ~done_c;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    // A simultaneous read+write request is treated as a store.
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write_i;
                    bus_addr_d  = addr_i;
                    bus_wdata_d = wdata_i;
                    bus_wstrb_d = mem_write_i ? wstrb_i : 4'h0;
                    state_d     = REQ;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            REQ: begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid_i) begin
                        mem_rdata_d = bus_rdata_i;
                        state_d     = DONE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus_rvalid_i) begin
                    mem_rdata_d = bus_rdata_i;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        if (abort_c) begin
            bus_req_d   = 1'b0;
            mem_rdata_d = 32'h0;
            fault_d     = 1'b1;
            state_d     = DONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    // Freeze is combinational so the first access cycle already holds the pipeline.
    assign stall_o        = ~rst & (((state_q == IDLE) & access_c) |
                                    (state_q == REQ) | (state_q == RESP));
    assign memwb_bubble_o = stall_o;

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign mem_rdata_o = mem_rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: transaction-level timing model plus per-cycle compare.
module tb_mem_access_ctrl;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, memwb_bubble_o, fault_o;
    logic [31:0] mem_rdata_o;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .memwb_bubble_o(memwb_bubble_o),
        .mem_rdata_o(mem_rdata_o), .fault_o(fault_o)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int stall_cnt = 0;
    logic chk_en = 1'b0;

    // Expected outputs: per-cycle flags plus the bus/readback values the model says are latched.
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_fault = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
    logic [3:0]  m_wstrb = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("bubble", 32'(memwb_bubble_o), 32'(exp_stall));
            chk("bus_req", 32'(bus_req_o), 32'(exp_req));
            chk("bus_we", 32'(bus_we_o), 32'(m_we));
            chk("bus_addr", bus_addr_o, m_addr);
            chk("bus_wdata", bus_wdata_o, m_wdata);
            chk("bus_wstrb", 32'(bus_wstrb_o), 32'(m_wstrb));
            chk("mem_rdata", mem_rdata_o, m_rdata);
            chk("fault", 32'(fault_o), 32'(exp_fault));
            if (stall_o) stall_cnt++;
        end
    end

    // Non-access cycles; spur drives stray gnt/rvalid and a valid-but-no-op slot.
    task automatic idle(input int n, input logic spur);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            valid_i      = spur;
            mem_read_i   = ~spur;
            mem_write_i  = ~spur;
            addr_i       = $urandom();
            wdata_i      = $urandom();
            wstrb_i      = 4'hF;
            bus_gnt_i    = spur;
            bus_rvalid_i = spur;
            bus_rdata_i  = $urandom();
            exp_stall    = 1'b0;
            exp_req      = 1'b0;
            exp_fault    = 1'b0;
        end
    endtask

    // One EXMEM instruction held until its done cycle; g = REQ wait cycles before gnt,
    // r = cycles from gnt to rvalid. kc is the 1-based bus cycle on which it completes.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input int g, input int r, input logic [31:0] rdat);
        bit is_wr;
        bit ab;
        int kc;
        int d;
        is_wr = wr;
        kc    = is_wr ? g + 1 : g + 1 + r;
        ab    = TO_EN && (kc > TO);
        d     = ab ? TO + 1 : kc + 1;
        stall_cnt = 0;
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1;
            valid_i      = 1'b1;
            mem_read_i   = rd;
            mem_write_i  = wr;
            addr_i       = a;
            wdata_i      = wd;
            wstrb_i      = ws;
            bus_gnt_i    = (k >= g + 1);
            bus_rvalid_i = !is_wr && (k == g + 1 + r);
            bus_rdata_i  = bus_rvalid_i ? rdat : 32'($urandom());
            exp_stall    = (k < d);
            exp_req      = (k >= 1) && (k <= g + 1) && (k < d);
            exp_fault    = ab && (k == d);
            if (k == 1) begin
                m_we    = is_wr;
                m_addr  = a;
                m_wdata = wd;
                m_wstrb = is_wr ? ws : 4'h0;
            end
            if (k == d) m_rdata = ab ? 32'h0 : (is_wr ? m_rdata : rdat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        addr_i = 32'hFFFF_FFFC; wdata_i = 32'hFFFF_FFFF; wstrb_i = 4'hF;
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_bubble", 32'(memwb_bubble_o), 32'h0);
        chk("rst_req", 32'(bus_req_o), 32'h0);
        chk("rst_we", 32'(bus_we_o), 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_wstrb", 32'(bus_wstrb_o), 32'h0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_fault", 32'(fault_o), 32'h0);
        valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0);
        chk("store_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("store_rdata_kept", mem_rdata_o, 32'h0);
        idle(1, 1'b1);

        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 3, 32'h1234_5678);
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        chk("long_load_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("long_load_rdata", mem_rdata_o, 32'h0);
`else
        chk("long_load_stall_cycles", 32'(stall_cnt), 32'd7);
        chk("long_load_rdata", mem_rdata_o, 32'h1234_5678);
`endif
        idle(1, 1'b0);

        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 32'hA5A5_A5A5);
        chk("fast_load_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("fast_load_rdata", mem_rdata_o, 32'hA5A5_A5A5);

        access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 1, 32'h0BAD_BEEF);
        chk("load_r1_stall_cycles", 32'(stall_cnt), 32'd3);

        // Back-to-back EXMEM slots: load then a read+write instruction (a store).
        access(1'b1, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 1, 0, 32'h1111_2222);
        access(1'b1, 1'b1, 32'h0000_0110, 32'hDEAD_BEEF, 4'h3, 1, 0, 32'h0);
        idle(2, 1'b1);

        // Completes exactly on the expiry cycle, then a load and a store that stall long.
        access(1'b1, 1'b0, 32'h0000_0114, 32'h0, 4'h0, 0, 3, 32'h55AA_55AA);
        chk("edge_load_rdata", mem_rdata_o, 32'h55AA_55AA);
        access(1'b1, 1'b0, 32'h0000_0118, 32'h0, 4'h0, 20, 0, 32'h7777_8888);
        access(1'b0, 1'b1, 32'h0000_011C, 32'h0102_0304, 4'hC, 5, 0, 32'h0);
        idle(2, 1'b0);

        // Reset in the first REQ cycle abandons the access.
        chk_en = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h0000_0200;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(bus_req_o), 32'h1);
        chk("pre_rst_addr", bus_addr_o, 32'h0000_0200);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_req_o), 32'h0);
        chk("mid_rst_stall", 32'(stall_o), 32'h0);
        chk("mid_rst_addr", bus_addr_o, 32'h0);
        chk("mid_rst_rdata", mem_rdata_o, 32'h0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        rst = 1'b0;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0; m_rdata = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
        chk_en = 1'b1;
        idle(3, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0300, 32'h89AB_CDEF, 4'h1, 1, 0, 32'h0);
        idle(2, 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the data-memory access of the MEM stage against a variable-latency bus with a req/gnt/rvalid handshake.
- Freezes the upstream pipeline registers while an access is outstanding.
- Injects bubbles into MEMWB while the access is outstanding, and supplies the captured read data to MEMWB's mem_rdata input.
- Sits between the EXMEM register outputs and the data bus, alongside MEMWB.

Parameters:
- TIMEOUT_CYC, 255, max cycles spent in REQ+RESP before abort (used only with the optional feature)
- CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYC

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  EXMEM holds a valid instruction
- mem_read_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store
- addr_i  in  32  byte address from ALU
- wdata_i  in  32  store data
- wstrb_i  in  4  store byte enables
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1=write, registered
- bus_addr_o  out  32  latched address
- bus_wdata_o  out  32  latched write data
- bus_wstrb_o  out  4  latched byte enables, 0 for reads
- bus_gnt_i  in  1  bus accepts request this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data
- stall_o  out  1  hold PC/IFID/IDEX/EXMEM, combinational
- memwb_bubble_o  out  1  load zero control into MEMWB, equals stall_o
- mem_rdata_o  out  32  captured load data to MEMWB
- fault_o  out  1  bus timeout pulse

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- An access exists when valid_i & (mem_read_i | mem_write_i).
- If mem_read_i and mem_write_i are both set, the access is a write.
- IDLE, no access: stall_o=0, remain.
- IDLE, access present: stall_o=1.
  - Latch addr_i/wdata_i/wstrb_i and direction into the bus_* registers.
  - Set bus_req_o=1. Next state REQ.
- REQ: stall_o=1, bus_req_o held 1, bus fields stable.
  - On bus_gnt_i, drop bus_req_o next edge.
  - Write with gnt: go to DONE.
  - Read with gnt and no rvalid: go to RESP.
  - Read with gnt and bus_rvalid_i in the same cycle: capture bus_rdata_i, go to DONE.
- RESP: stall_o=1, bus_req_o=0. On bus_rvalid_i, capture bus_rdata_i into mem_rdata_o, go to DONE.
- DONE: stall_o=0, so the pipeline advances at this edge. mem_rdata_o stable. Next state IDLE unconditionally.
  - The new EXMEM instruction is evaluated in the following IDLE cycle.
  - The same instruction is never issued twice.
- bus_rvalid_i outside REQ/RESP is ignored. bus_gnt_i outside REQ is ignored.
- mem_rdata_o holds its last captured value until the next load capture; stores do not modify it.
- Latency with zero-wait bus:
  - Store: 3 cycles IDLE→REQ→DONE, stall_o high 2 cycles.
  - Load with gnt and rvalid together: 3 cycles.
  - Load with rvalid one cycle after gnt: 4 cycles.
- stall_o is combinational from state and valid_i and is forced 0 while rst=1.
- Reset values (asynchronous, immediate):
  - state=IDLE
  - bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_wstrb_o=0
  - mem_rdata_o=0, fault_o=0, counter=0
- Reset mid-access: bus_req_o drops immediately, the access is abandoned, and nothing is replayed after reset.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYC without completion, force bus_req_o=0, set mem_rdata_o=0, and go to DONE.
  - fault_o pulses 1 for exactly the DONE cycle.
  - Completion and expiry in the same cycle: completion wins, no fault.
- Undefined: no counter; REQ/RESP wait indefinitely; fault_o tied 0.

Test Plan:
- Reset → all outputs zero. rst asserted in REQ with bus_req_o=1 → bus_req_o=0 same cycle, state IDLE, stall_o=0.
- Store, addr 0x0000_0040, wdata 0xCAFEF00D, wstrb 0xF, gnt on first REQ cycle:
  - bus_req_o high 1 cycle, bus_we_o=1.
  - stall_o high 2 cycles, DONE on cycle 3.
  - mem_rdata_o unchanged.
- Load, addr 0x100, gnt after 2 wait cycles, rvalid 3 cycles after gnt with rdata 0x1234_5678:
  - stall_o high 7 cycles.
  - mem_rdata_o=0x12345678 in DONE.
  - memwb_bubble_o mirrors stall_o throughout.
- Load with gnt and rvalid in the same cycle, rdata 0xA5A5A5A5 → DONE next cycle, 3-cycle latency.
- Back-to-back load then store in consecutive EXMEM slots:
  - Second access begins only in the IDLE cycle after DONE.
  - Spurious rvalid in IDLE does not alter mem_rdata_o.
- With MEM_ACCESS_CTRL_TIMEOUT_EN, TIMEOUT_CYC=4, gnt never asserted:
  - Abort after 4 cycles in REQ.
  - fault_o=1 for one cycle, mem_rdata_o=0.
  - Pipeline resumes.
